// File: rtl/cu_power_sequencer.sv
// Power sequencer for the shared L2 and NUM_CU compute units of one kernel launch.
// Brings L2 out of reset, releases the masked CUs, drains/gates each CU on request, then shuts down.
module cu_power_sequencer #(
  parameter int NUM_CU       = 4,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CU-1:0] cu_mask_i,
  input  logic [NUM_CU-1:0] cu_sleep_req_i,
  input  logic [NUM_CU-1:0] cu_delay_sleep_i,
  output logic [NUM_CU-1:0] cu_clk_en_o,
  output logic [NUM_CU-1:0] cu_rst_n_o,
  output logic              l2_clk_en_o,
  output logic              l2_rst_n_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_MAXV = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAXV + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CNT_MAXV);

  typedef enum logic [2:0] {
    G_IDLE, G_L2_RESET, G_CU_START, G_ACTIVE, G_FINISH
  } g_state_e;

  typedef enum logic [2:0] {
    CU_OFF, CU_RESET, CU_RUN, CU_DRAIN, CU_GATED
  } cu_state_e;

  g_state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CU-1:0] mask_q, mask_d;

  cu_state_e        cu_state_q [NUM_CU];
  cu_state_e        cu_state_d [NUM_CU];
  logic [CNT_W-1:0] cu_cnt_q   [NUM_CU];
  logic [CNT_W-1:0] cu_cnt_d   [NUM_CU];

  logic [NUM_CU-1:0] cu_clk_en_q, cu_clk_en_d;
  logic [NUM_CU-1:0] cu_rst_n_q, cu_rst_n_d;
  logic              l2_clk_en_q, l2_clk_en_d;
  logic              l2_rst_n_q, l2_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic launch, stop, all_gated;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    cu_state_d = cu_state_q;
    cu_cnt_d   = cu_cnt_q;
    launch     = 1'b0;
    stop       = 1'b0;

    all_gated = 1'b1;
    for (int i = 0; i < NUM_CU; i++) begin
      if (mask_q[i] && (cu_state_q[i] != CU_GATED)) all_gated = 1'b0;
    end

    unique case (state_q)
      G_IDLE: begin
        if (start_i && !abort_i && (|cu_mask_i)) begin
          mask_d  = cu_mask_i;
          cnt_d   = '0;
          state_d = G_L2_RESET;
        end
      end
      G_L2_RESET: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = G_CU_START;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      G_CU_START: begin
        launch  = 1'b1;
        state_d = G_ACTIVE;
      end
      G_ACTIVE: begin
        if (all_gated) state_d = G_FINISH;
      end
      G_FINISH: begin
        stop    = 1'b1;
        state_d = G_IDLE;
      end
      default: state_d = G_IDLE;
    endcase

    if (abort_i && (state_q != G_IDLE)) begin
      stop    = 1'b1;
      state_d = G_IDLE;
    end

    for (int i = 0; i < NUM_CU; i++) begin
      unique case (cu_state_q[i])
        CU_OFF: begin
          if (launch && mask_q[i]) begin
            cu_state_d[i] = CU_RESET;
            cu_cnt_d[i]   = '0;
          end
        end
        CU_RESET: begin
          if (cu_cnt_q[i] == RST_LAST) begin
            cu_state_d[i] = CU_RUN;
            cu_cnt_d[i]   = '0;
          end else begin
            cu_cnt_d[i] = sat_inc(cu_cnt_q[i]);
          end
        end
        CU_RUN: begin
          if (cu_sleep_req_i[i]) begin
            cu_state_d[i] = CU_DRAIN;
            cu_cnt_d[i]   = '0;
          end
        end
        CU_DRAIN: begin
          // Any outstanding L2 request restarts the quiet-cycle count.
          if (cu_delay_sleep_i[i]) begin
            cu_cnt_d[i] = '0;
          end else if (cu_cnt_q[i] == DRAIN_LAST) begin
            cu_state_d[i] = CU_GATED;
            cu_cnt_d[i]   = '0;
          end else begin
            cu_cnt_d[i] = sat_inc(cu_cnt_q[i]);
          end
        end
        CU_GATED: ;
        default: cu_state_d[i] = CU_OFF;
      endcase
      if (stop) begin
        cu_state_d[i] = CU_OFF;
        cu_cnt_d[i]   = '0;
      end
    end

    // Outputs decode the next state so the registered copies line up with the state register.
    for (int i = 0; i < NUM_CU; i++) begin
      cu_clk_en_d[i] = (cu_state_d[i] == CU_RESET) || (cu_state_d[i] == CU_RUN) ||
                       (cu_state_d[i] == CU_DRAIN);
      cu_rst_n_d[i]  = (cu_state_d[i] == CU_RUN) || (cu_state_d[i] == CU_DRAIN) ||
                       (cu_state_d[i] == CU_GATED);
    end
    l2_clk_en_d = (state_d != G_IDLE);
    l2_rst_n_d  = (state_d == G_CU_START) || (state_d == G_ACTIVE) || (state_d == G_FINISH);
    busy_d      = (state_d != G_IDLE);
    done_d      = (state_q == G_FINISH) && !abort_i;
  end

  // NOTE: sequential state uses non-blocking assignments only; the per-CU arrays are
  // control state, not storage, so they are reset like every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= G_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      for (int i = 0; i < NUM_CU; i++) begin
        cu_state_q[i] <= CU_OFF;
        cu_cnt_q[i]   <= '0;
      end
      cu_clk_en_q <= '0;
      cu_rst_n_q  <= '0;
      l2_clk_en_q <= 1'b0;
      l2_rst_n_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      cu_state_q  <= cu_state_d;
      cu_cnt_q    <= cu_cnt_d;
      cu_clk_en_q <= cu_clk_en_d;
      cu_rst_n_q  <= cu_rst_n_d;
      l2_clk_en_q <= l2_clk_en_d;
      l2_rst_n_q  <= l2_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cu_clk_en_o = cu_clk_en_q;
  assign cu_rst_n_o  = cu_rst_n_q;
  assign l2_clk_en_o = l2_clk_en_q;
  assign l2_rst_n_o  = l2_rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
